// File: rtl/dmem_rd_align.sv
// dmem_rd_align: selects the returning SRAM bank, aligns/extends load data, and returns it in order.
// Optional misaligned-access flagging is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_rd_align #(
    parameter int BANKS = 4,
    parameter int DW    = 32,
    parameter int LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(BANKS)-1:0] req_sel,
    input  logic [2:0]               req_funct3,
    input  logic [1:0]               req_off,
    input  logic [BANKS*DW-1:0]      DO_flat,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_err
);

    localparam int SW    = $clog2(BANKS);
    localparam int DEPTH = LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(LAT + 2);
    localparam int TW    = CW + 1;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [2:0]    funct3;
        logic [1:0]    off;
    } tag_t;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } ent_t;

    logic [LAT-1:0] tv_q;
    tag_t           tg_q [LAT];
    ent_t           mem_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rdy_q;

    logic           acc, push, pop;
    tag_t           ex;
    logic [DW-1:0]  word;
    logic [7:0]     byt;
    logic [15:0]    half;
    ent_t           fmt;
    logic [TW-1:0]  tot;

    assign acc  = req_valid && req_ready;
    assign push = tv_q[LAT-1];
    assign ex   = tg_q[LAT-1];
    assign pop  = rsp_valid && rsp_ready;

    // outstanding work = tags still waiting on SRAM + results already buffered
    always_comb begin
        tot = TW'(cnt_q);
        for (int k = 0; k < LAT; k++) begin
            tot = tot + TW'(tv_q[k]);
        end
    end

    assign req_ready = rdy_q && (tot < TW'(DEPTH));

    // ready is held off until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // tag pipeline follows each request until its SRAM data returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tg_q[k] <= '0;
            end
        end else begin
            tv_q[0] <= acc;
            tg_q[0] <= '{req_sel, req_funct3, req_off};
            for (int k = 1; k < LAT; k++) begin
                tv_q[k] <= tv_q[k-1];
                tg_q[k] <= tg_q[k-1];
            end
        end
    end

    // pick the returning bank and align/extend according to the load type
    always_comb begin
        word     = DO_flat[ex.sel*DW +: DW];
        byt      = word[{ex.off, 3'b000} +: 8];
        half     = ex.off[1] ? word[31:16] : word[15:0];
        fmt      = '0;
        fmt.data = word;
        case (ex.funct3)
            3'b000:  fmt.data = {{(DW-8){byt[7]}}, byt};
            3'b001:  fmt.data = {{(DW-16){half[15]}}, half};
            3'b100:  fmt.data = {{(DW-8){1'b0}}, byt};
            3'b101:  fmt.data = {{(DW-16){1'b0}}, half};
            default: fmt.data = word;
        endcase
`ifdef DMEM_MISALIGN_CHK_EN
        if (((ex.funct3 == 3'b001 || ex.funct3 == 3'b101) && ex.off[0]) ||
            (ex.funct3 == 3'b010 && ex.off != 2'b00)) begin
            fmt.err  = 1'b1;
            fmt.data = '0;
        end
`endif
    end

    // FIFO pointer and occupancy next-state; pointers wrap at DEPTH
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            wr_d = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // response FIFO storage and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q] <= fmt;
            end
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rsp_valid = (cnt_q != '0);
    assign rsp_data  = rsp_valid ? mem_q[rd_q].data : '0;
    assign rsp_err   = rsp_valid & mem_q[rd_q].err;

endmodule

// File: tb/tb_dmem_rd_align.sv
// tb_dmem_rd_align: directed checks of dmem_rd_align with LAT=1/BANKS=4 and LAT=2/BANKS=8.
// Expected values are hand-computed; a small queue tracks order in the streaming run.
module tb_dmem_rd_align;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

`ifdef DMEM_MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    localparam logic [127:0] A_FLAT = {32'h55667788, 32'h8899AABB,
                                       32'hCAFEF00D, 32'h12345678};
    localparam logic [255:0] B_FLAT = {32'h01238000, 32'hA6A6A6A6,
                                       32'h7FFF1234, 32'hA4A4A4A4,
                                       32'hA3A3A3A3, 32'hA2A2A2A2,
                                       32'hA1A1A1A1, 32'h0BADF00D};

    logic clk = 1'b0;
    logic rst_n;

    logic         a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [1:0]   a_req_sel, a_off;
    logic [2:0]   a_funct3;
    logic [31:0]  a_rsp_data;
    logic [127:0] a_nxt, a_pipe;

    logic         b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [2:0]   b_req_sel, b_funct3;
    logic [1:0]   b_off;
    logic [31:0]  b_rsp_data;
    logic [255:0] b_nxt, b_p0, b_p1;

    int pass_n = 0;
    int fail_n = 0;
    int tot_n  = 0;

    always #5 clk = ~clk;

    dmem_rd_align #(.BANKS(4), .DW(32), .LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_sel(a_req_sel), .req_funct3(a_funct3), .req_off(a_off),
        .DO_flat(a_pipe),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
    );

    dmem_rd_align #(.BANKS(8), .DW(32), .LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_sel(b_req_sel), .req_funct3(b_funct3), .req_off(b_off),
        .DO_flat(b_p1),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
    );

    // SRAM stand-ins: data for an accepted request appears LAT cycles later
    always @(posedge clk) begin
        a_pipe <= (a_req_valid && a_req_ready) ? a_nxt : {4{32'hDEADBEEF}};
        b_p0   <= (b_req_valid && b_req_ready) ? b_nxt : {8{32'hDEADBEEF}};
        b_p1   <= b_p0;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tot_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp);
        end
    endtask

    task automatic a_chk(string tag, logic [1:0] sel, logic [2:0] f3,
                         logic [1:0] off, logic [31:0] ed, logic ee);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_sel   = sel;
        a_funct3    = f3;
        a_off       = off;
        a_nxt       = A_FLAT;
        @(negedge clk);
        a_req_valid = 1'b0;
        chk({tag, "_early"}, 32'(a_rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_v"}, 32'(a_rsp_valid), 32'd1);
        chk(tag, a_rsp_data, ed);
        chk({tag, "_err"}, 32'(a_rsp_err), 32'(ee));
    endtask

    task automatic b_chk(string tag, logic [2:0] sel, logic [2:0] f3,
                         logic [1:0] off, logic [31:0] ed);
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_sel   = sel;
        b_funct3    = f3;
        b_off       = off;
        b_nxt       = B_FLAT;
        @(negedge clk);
        b_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_v"}, 32'(b_rsp_valid), 32'd1);
        chk(tag, b_rsp_data, ed);
    endtask

    initial begin
        int acc_n;
        int got_n;
        logic [31:0] w;
        logic [31:0] exp_q[$];

        rst_n       = 1'b0;
        a_req_valid = 1'b0; a_req_sel = '0; a_funct3 = '0; a_off = '0;
        a_rsp_ready = 1'b1; a_nxt = '0;
        b_req_valid = 1'b0; b_req_sel = '0; b_funct3 = '0; b_off = '0;
        b_rsp_ready = 1'b1; b_nxt = '0;

        #1;
        chk("rst_a_rdy", 32'(a_req_ready), 32'd0);
        chk("rst_a_v", 32'(a_rsp_valid), 32'd0);
        chk("rst_a_data", a_rsp_data, 32'd0);
        chk("rst_a_err", 32'(a_rsp_err), 32'd0);
        chk("rst_b_rdy", 32'(b_req_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_rdy", 32'(a_req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_pre", 32'(a_req_ready), 32'd0);
        @(negedge clk);
        chk("rel_a_rdy", 32'(a_req_ready), 32'd1);
        chk("rel_b_rdy", 32'(b_req_ready), 32'd1);

        a_chk("lb0",   2'd2, F_LB,  2'd0, 32'hFFFFFFBB, 1'b0);
        a_chk("lbu0",  2'd2, F_LBU, 2'd0, 32'h000000BB, 1'b0);
        a_chk("lb1",   2'd2, F_LB,  2'd1, 32'hFFFFFFAA, 1'b0);
        a_chk("lbu3",  2'd2, F_LBU, 2'd3, 32'h00000088, 1'b0);
        a_chk("lh0",   2'd2, F_LH,  2'd0, 32'hFFFFAABB, 1'b0);
        a_chk("lhu2",  2'd2, F_LHU, 2'd2, 32'h00008899, 1'b0);
        a_chk("lh2",   2'd2, F_LH,  2'd2, 32'hFFFF8899, 1'b0);
        a_chk("b0lb3", 2'd0, F_LB,  2'd3, 32'h00000012, 1'b0);
        a_chk("b0lh2", 2'd0, F_LH,  2'd2, 32'h00001234, 1'b0);
        a_chk("b0lbu1", 2'd0, F_LBU, 2'd1, 32'h00000056, 1'b0);
        a_chk("lw0",   2'd2, F_LW,  2'd0, 32'h8899AABB, 1'b0);
        a_chk("f011",  2'd2, 3'b011, 2'd0, 32'h8899AABB, 1'b0);
        a_chk("f111",  2'd1, 3'b111, 2'd2, 32'hCAFEF00D, 1'b0);
        a_chk("lw_mis", 2'd2, F_LW, 2'd1, MIS ? 32'h0 : 32'h8899AABB, MIS);
        a_chk("lh_mis", 2'd2, F_LH, 2'd1, MIS ? 32'h0 : 32'hFFFFAABB, MIS);
        a_chk("lhu_mis", 2'd3, F_LHU, 2'd3, MIS ? 32'h0 : 32'h00005566, MIS);

        b_chk("b5lh2",  3'd5, F_LH,  2'd2, 32'h00007FFF);
        b_chk("b5lb2",  3'd5, F_LB,  2'd2, 32'hFFFFFFFF);
        b_chk("b5lbu2", 3'd5, F_LBU, 2'd2, 32'h000000FF);
        b_chk("b7lb1",  3'd7, F_LB,  2'd1, 32'hFFFFFF80);
        b_chk("b0lw",   3'd0, F_LW,  2'd0, 32'h0BADF00D);

        // back-to-back requests with the consumer stalled
        @(negedge clk);
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        b_req_sel   = 3'd3;
        b_funct3    = F_LW;
        b_off       = 2'd0;
        acc_n       = 0;
        for (int i = 0; i < 6; i++) begin
            b_nxt = {8{32'hDEADBEEF}};
            b_nxt[3*32 +: 32] = 32'h1000_0000 + 32'(acc_n);
            if (b_req_ready) acc_n++;
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        chk("burst_acc", 32'(acc_n), 32'd3);
        chk("burst_rdy", 32'(b_req_ready), 32'd0);
        chk("burst_v", 32'(b_rsp_valid), 32'd1);
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("drain_v", 32'(b_rsp_valid), 32'd1);
            chk("drain_d", b_rsp_data, 32'h1000_0000 + 32'(k));
            @(negedge clk);
        end
        chk("drain_empty", 32'(b_rsp_valid), 32'd0);
        chk("drain_rdy", 32'(b_req_ready), 32'd1);

        // streaming with a throttled consumer: push and pop overlap
        acc_n = 0;
        got_n = 0;
        b_funct3 = F_LW;
        b_off    = 2'd0;
        for (int i = 0; i < 36; i++) begin
            b_rsp_ready = (i % 3 != 2);
            if (b_rsp_valid && b_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", b_rsp_data, 32'hFFFF_FFFF);
                end else begin
                    chk("stream_d", b_rsp_data, exp_q.pop_front());
                end
                got_n++;
            end
            b_req_valid = (i < 24);
            b_req_sel   = 3'(acc_n);
            w           = 32'h5000_0000 + 32'(acc_n);
            b_nxt       = {8{32'hDEADBEEF}};
            b_nxt[32*(acc_n % 8) +: 32] = w;
            if (b_req_valid && b_req_ready) begin
                exp_q.push_back(w);
                acc_n++;
            end
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        chk("stream_cnt", 32'(got_n), 32'(acc_n));
        chk("stream_left", 32'(exp_q.size()), 32'd0);
        chk("stream_idle", 32'(b_rsp_valid), 32'd0);

        // reset with buffered and in-flight responses
        b_rsp_ready = 1'b0;
        b_req_valid = 1'b1;
        b_req_sel   = 3'd5;
        b_nxt       = B_FLAT;
        repeat (3) @(negedge clk);
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("mid_v", 32'(b_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 32'(b_rsp_valid), 32'd0);
        chk("mid_rst_d", b_rsp_data, 32'd0);
        chk("mid_rst_rdy", 32'(b_req_ready), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_v", 32'(b_rsp_valid), 32'd0);
        end
        chk("post_rst_rdy", 32'(b_req_ready), 32'd1);

        b_chk("post_lh", 3'd5, F_LHU, 2'd0, 32'h00001234);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule

// File: doc/dmem_rd_align.md
DMEM_RD_ALIGN -- requirements
Module: dmem_rd_align

Interface
REQ-001 Parameter BANKS, default 4, number of SRAM banks (power of 2, 2..16).
REQ-002 Parameter DW, default 32, bank data width (fixed at 32 for byte/half formatting).
REQ-003 Parameter LAT, default 1, SRAM read latency in cycles (1..3).
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port req_valid  input  1  read request issued to SRAM this cycle.
REQ-007 Port req_ready  output  1  block can accept a request.
REQ-008 Port req_sel  input  log2(BANKS)  bank whose DO returns the data.
REQ-009 Port req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 Port req_off  input  2  byte offset within the word.
REQ-011 Port DO_flat  input  BANKS*DW  concatenated bank outputs; bank k at bits [k*DW +: DW].
REQ-012 Port rsp_valid  output  1  formatted load data available.
REQ-013 Port rsp_ready  input  1  consumer accepts rsp_data.
REQ-014 Port rsp_data  output  DW  aligned, extended load data.
REQ-015 Port rsp_err  output  1  misaligned access flag (only with DMEM_MISALIGN_CHK_EN).

Function
REQ-016 Request accepted on a cycle with req_valid and req_ready both high; sel/funct3/off captured into a LAT-stage tag pipeline with a valid bit per stage.
REQ-017 Tag exits stage LAT on the same edge DO_flat carries its data; bank req_sel is selected and formatted that cycle.
REQ-018 Formatting: word = DO[sel]; LB/LBU take byte off, LH/LHU take half off[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW returns word unchanged.
REQ-019 Undefined funct3 codes (011, 110, 111) return word unchanged, rsp_err low.
REQ-020 Formatted results enter a response FIFO of depth LAT+1; rsp_valid = FIFO non-empty, rsp_data/rsp_err = head entry.
REQ-021 Head popped on rsp_valid && rsp_ready.
REQ-022 Credit rule: req_ready = (in-flight tags + FIFO occupancy) < LAT+1; SRAM data is never dropped.
REQ-023 Push and pop in the same cycle with FIFO full or empty: occupancy unchanged, order preserved, no overflow/underflow.
REQ-024 Bypass: empty FIFO plus a tag exiting stage LAT -> rsp_valid high the next cycle (total request-to-rsp_valid latency LAT+1).
REQ-025 FIFO pointers wrap modulo LAT+1; occupancy counter width log2(LAT+2).
REQ-026 Responses returned strictly in request order.

Reset
REQ-027 rst_n low asynchronously clears all tag valid bits, FIFO pointers and occupancy.
REQ-028 During reset: rsp_valid 0, rsp_data 0, rsp_err 0, req_ready 0; req_ready 1 from the first clk edge after rst_n deasserts.
REQ-029 Reset mid-operation discards in-flight and buffered responses; none are emitted afterwards.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHK_EN defined: LH/LHU with off[0]=1 or LW with off!=0 returns rsp_err=1, rsp_data=0.
REQ-031 Macro undefined: no check; misaligned LH uses half off[1], LW ignores off; rsp_err tied 0.

Verification
REQ-032 LAT=1, bank2 DO=0x8899AABB, LB off=0 -> one cycle after DO valid, rsp_data=0xFFFFFFBB; LBU -> 0x000000BB.
REQ-033 BANKS=8, sel=5, LH off=2, DO[5]=0x7FFF1234 -> rsp_data=0x00007FFF, other banks ignored.
REQ-034 LAT=2, rsp_ready held 0, back-to-back requests -> exactly 3 accepted, req_ready low, 3 responses drained in order once rsp_ready=1.
REQ-035 Full FIFO with simultaneous pop and new tag exit -> occupancy stays 3, no data lost or duplicated.
REQ-036 DMEM_MISALIGN_CHK_EN, LW off=1 -> rsp_err=1, rsp_data=0; without macro -> rsp_err=0, full word returned.
REQ-037 rst_n pulsed low with 2 responses buffered -> rsp_valid 0 immediately, no stale response after release.
